// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register-write initiator
// Also holds the per-quarter SCL/SDA drive table used by the FSM.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h6A;

  // Returns {scl_oe, sda_oe} for quarter ph of a bit in state st; 1 pulls the line low.
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph,
                                            input logic tx_bit);
    logic scl_low;
    logic sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      ST_START: begin
        scl_low = 1'b0;
        sda_low = (ph >= Q2);
      end
      ST_ADDR, ST_REG, ST_DATA: begin
        scl_low = (ph <= Q1);
        sda_low = ~tx_bit;
      end
      ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
        scl_low = (ph <= Q1);
        sda_low = 1'b0;
      end
      ST_STOP: begin
        scl_low = (ph == Q0);
        sda_low = (ph <= Q1);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - SCL quarter-period timer with clock-stretch hold
// Counts CLK_DIV cycles per quarter, walks phases Q0..Q3 and flags quarter boundaries.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       scl_i,
  output logic [1:0] phase,
  output logic       q_first,
  output logic       q_last,
  output logic       q_pre_last
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          hold;

  // A slave holding SCL low at Q2 entry freezes the count, so Q2 restarts once SCL rises.
  assign hold = (phase == Q2) && (cnt == '0) && !scl_i;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (cnt == CW'(CLK_DIV - 1)) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign q_first    = run && (cnt == '0);
  assign q_last     = run && (cnt == CW'(CLK_DIV - 1));
  assign q_pre_last = run && (cnt == CW'(CLK_DIV - 2));

endmodule

// File: rtl/i2c_master_writer.sv
// rtl/i2c_master_writer.sv - single-master I2C register-write initiator
// START, {dev,W}, reg, N data bytes, STOP; aborts to STOP on any NACK.
module i2c_master_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV   = 125,
  parameter int MAX_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [4:0] byte_count,
  input  logic [7:0] wr_data,
  output logic [4:0] data_idx,
  output logic       data_ld,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl_oe,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i
);

  state_t     state;
  logic [7:0] sr;
  logic [3:0] bit_cnt;
  logic [4:0] n_bytes;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic       more;
  logic       ack_bit;

  logic [1:0] phase;
  logic       q_first;
  logic       q_last;
  logic       q_pre_last;
  logic       bit_last;
  logic       in_ack;
  logic [4:0] n_clamped;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (state != ST_IDLE),
    .scl_i      (scl_i),
    .phase      (phase),
    .q_first    (q_first),
    .q_last     (q_last),
    .q_pre_last (q_pre_last)
  );

  assign bit_last  = q_last && (phase == Q3);
  assign in_ack    = state inside {ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK};
  assign n_clamped = (byte_count > 5'(MAX_BYTES)) ? 5'(MAX_BYTES) : byte_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      data_ld   <= 1'b0;
      data_idx  <= '0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      sr        <= '0;
      bit_cnt   <= '0;
      n_bytes   <= '0;
      dev_q     <= DEFAULT_DEV_ADDR;
      reg_q     <= '0;
      more      <= 1'b0;
      ack_bit   <= ACK;
    end else begin
      done    <= 1'b0;
      data_ld <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state              <= ST_START;
          busy               <= 1'b1;
          ack_error          <= 1'b0;
          dev_q              <= dev_addr;
          reg_q              <= reg_addr;
          n_bytes            <= n_clamped;
          data_idx           <= '0;
          bit_cnt            <= '0;
          more               <= 1'b0;
          {scl_oe, sda_oe}   <= line_drive(ST_START, Q0, 1'b1);
        end
      end else begin
        if (in_ack && (phase == Q3) && q_first)
          ack_bit <= sda_i;

        // Fetch the next byte in the final cycle of the ACK bit that precedes it.
        if ((state == ST_REG_ACK || state == ST_DATA_ACK) && (phase == Q3) && q_pre_last &&
            more && (ack_bit == ACK))
          data_ld <= 1'b1;

        if (q_last && (phase != Q3))
          {scl_oe, sda_oe} <= line_drive(state, phase + 2'd1, sr[7]);

        if (bit_last) begin
          case (state)
            ST_START: begin
              state            <= ST_ADDR;
              sr               <= {dev_q, 1'b0};
              bit_cnt          <= '0;
              {scl_oe, sda_oe} <= line_drive(ST_ADDR, Q0, dev_q[6]);
            end
            ST_ADDR, ST_REG, ST_DATA: begin
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                case (state)
                  ST_ADDR: state <= ST_ADDR_ACK;
                  ST_REG: begin
                    state <= ST_REG_ACK;
                    more  <= (n_bytes != 5'd0);
                  end
                  default: begin
                    state <= ST_DATA_ACK;
                    more  <= (data_idx != n_bytes - 5'd1);
                    if (data_idx != n_bytes - 5'd1)
                      data_idx <= data_idx + 5'd1;
                  end
                endcase
                {scl_oe, sda_oe} <= line_drive(ST_DATA_ACK, Q0, 1'b1);
              end else begin
                sr               <= {sr[6:0], 1'b0};
                bit_cnt          <= bit_cnt + 4'd1;
                {scl_oe, sda_oe} <= line_drive(state, Q0, sr[6]);
              end
            end
            ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
              if (ack_bit == NACK) begin
                ack_error        <= 1'b1;
                state            <= ST_STOP;
                {scl_oe, sda_oe} <= line_drive(ST_STOP, Q0, 1'b1);
              end else if (state == ST_ADDR_ACK) begin
                state            <= ST_REG;
                sr               <= reg_q;
                {scl_oe, sda_oe} <= line_drive(ST_REG, Q0, reg_q[7]);
              end else if (more) begin
                state            <= ST_DATA;
                sr               <= wr_data;
                {scl_oe, sda_oe} <= line_drive(ST_DATA, Q0, wr_data[7]);
              end else begin
                state            <= ST_STOP;
                {scl_oe, sda_oe} <= line_drive(ST_STOP, Q0, 1'b1);
              end
            end
            default: begin
              state            <= ST_IDLE;
              busy             <= 1'b0;
              done             <= 1'b1;
              {scl_oe, sda_oe} <= 2'b00;
            end
          endcase
        end
      end
    end
  end

endmodule
